async_up_counter: RTL and testbench

ASYNC_UP_COUNTER -- requirements
Module: async_up_counter

---
 rtl/async_up_counter_pkg.sv | 16 +
 rtl/async_up_counter_ripple_tff_stage.sv | 26 ++
 rtl/async_up_counter.sv | 56 +++++
 tb/tb_async_up_counter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/async_up_counter_pkg.sv
// Shared constants and helpers for the ripple up/down counter.
package async_up_counter_pkg;

  localparam int WIDTH_DEFAULT = 3;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Counting up advances a stage on the falling edge of the stage below, so its clock is inverted.
  function automatic logic stage_clk_sel(input dir_e dir, input logic prev_bit);
    return (dir == DIR_UP) ? ~prev_bit : prev_bit;
  endfunction

endpackage

// File: rtl/async_up_counter_ripple_tff_stage.sv
// One ripple stage: T flip-flop with asynchronous active-high clear.
module ripple_tff_stage (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/async_up_counter.sv
// Ripple up/down counter: bit 0 runs on clk, each higher bit is clocked by the
// bit below through a direction mux held steady from the clk falling edge.
module async_up_counter
  import async_up_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_down,
  output logic [WIDTH-1:0] q
);

  dir_e             dir_q;
  dir_e             dir_d;
  logic [WIDTH-1:0] stage_clk;
  logic [WIDTH-1:0] stage_t;
  logic [WIDTH-1:0] cnt;

  always_comb begin
    dir_d = dir_e'(up_down);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      dir_q <= DIR_UP;
    end else begin
      dir_q <= dir_d;
    end
  end

  // Remuxing happens just after clk falls, so a mux-induced edge arrives while
  // clk is low and is ignored; genuine ripple edges all land while clk is high.
  always_comb begin
    stage_clk    = '0;
    stage_t      = '0;
    stage_clk[0] = clk;
    stage_t[0]   = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      stage_clk[i] = stage_clk_sel(dir_q, cnt[i-1]);
      stage_t[i]   = clk;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_stage
    ripple_tff_stage u_stage (
      .clk (stage_clk[g]),
      .rst (rst),
      .t   (stage_t[g]),
      .q   (cnt[g])
    );
  end

  assign q = cnt;

endmodule

// File: tb/tb_async_up_counter.sv
// Directed bench for async_up_counter (WIDTH=3): scoreboard of expected counts
// checked 1 ns before each rising edge, plus hold and reset checks.
module tb_async_up_counter;

  logic       clk;
  logic       rst;
  logic       up_down;
  logic [2:0] q;

  logic [2:0] model;
  logic [2:0] sb[$];
  int         pass_cnt;
  int         total_cnt;

  async_up_counter #(.WIDTH(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .up_down (up_down),
    .q       (q)
  );

  // clk high at 0, falls at 5, rises at 10, 20, 30, ...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: q=%0d expected %0d at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic check_pop(input string tag);
    logic [2:0] exp;
    if (sb.size() == 0) begin
      total_cnt++;
      $error("FAIL %s: scoreboard empty, q=%0d at t=%0t", tag, q, $time);
    end else begin
      exp = sb.pop_front();
      check(tag, q, exp);
    end
  endtask

  // Entered 4 ns after a rising edge; the new direction is held at the next
  // falling edge and governs the rising edge after it.
  task automatic step(input logic dir);
    logic [2:0] prev;
    prev    = model;
    up_down = dir;
    model   = dir ? (model + 3'd1) : (model - 3'd1);
    sb.push_back(model);
    #2;
    check("hold_after_negedge", q, prev);
    #3;
    check_pop("settle");
    #5;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    up_down   = 1'b1;
    model     = 3'd0;
    sb.push_back(3'd0);

    #1;
    check("reset_t1", q, 3'd0);
    #2;
    check("reset_t3", q, 3'd0);
    #1;
    model = 3'd1;
    sb.push_back(model);
    #1;
    rst = 1'b0;
    #1;
    check("after_release", q, 3'd0);
    #3;
    check_pop("settle_first");
    #5;

    for (int i = 0; i < 9; i++) step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1);

    check_pop("before_mid_reset");
    #2;
    rst     = 1'b1;
    up_down = 1'b0;
    #1;
    check("mid_reset_immediate", q, 3'd0);
    #5;
    check("reset_hold_over_edge", q, 3'd0);
    #4;
    rst = 1'b0;
    model = 3'd1;
    sb.push_back(3'd0);
    sb.push_back(model);
    #3;
    check_pop("post_reset_pre_edge");
    #5;
    // Held direction came out of reset as up, so the edge above counted up.
    for (int i = 0; i < 3; i++) step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    #5;
    check_pop("final_drain");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
